hmmm_multicycle_core: RTL and testbench

Parametrised multicycle successor to the single-cycle 4-bit HMMM core. It has a configurable data width, register count and PC width. Instruction fetch and data access go through separate valid/ready memory ports, so the core tolerates variable-latency memories. It adds HALT, illegal-opcode trapping and a sticky halted state, and sits between the instruction ROM and data RAM wrappers at the top level.

---
 rtl/hmmm_pkg.sv | 44 ++++
 rtl/hmmm_regfile_p.sv | 32 +++
 rtl/hmmm_multicycle_core.sv | 173 +++++++++++++++++
 tb/tb_hmmm_multicycle_core.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmmm_pkg.sv
// Shared types and instruction-field layout for the multicycle HMMM core.
package hmmm_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 8;
  localparam int RY_MSB  = 7;
  localparam int RY_LSB  = 4;
  localparam int RZ_MSB  = 3;
  localparam int RZ_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_HALT  = 4'h0,
    OP_SETN  = 4'h1,
    OP_LOAD  = 4'h2,
    OP_STORE = 4'h3,
    OP_ADD   = 4'h4,
    OP_SUB   = 4'h5,
    OP_AND   = 4'h6,
    OP_OR    = 4'h7,
    OP_JEQZN = 4'h8,
    OP_JNEZN = 4'h9,
    OP_JGTZN = 4'hA,
    OP_JLTZN = 4'hB,
    OP_JUMPN = 4'hC
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  function automatic logic [3:0] reg_idx(input logic [3:0] field, input int nregs);
    return 4'(int'(field) % nregs);
  endfunction

endpackage

// File: rtl/hmmm_regfile_p.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
module hmmm_regfile_p
  import hmmm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NREGS      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            ra_addr_i,
  output logic [DATA_WIDTH-1:0] ra_data_o,
  input  logic [3:0]            rb_addr_i,
  output logic [DATA_WIDTH-1:0] rb_data_o,
  input  logic                  we_i,
  input  logic [3:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 4'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o = (ra_addr_i == 4'd0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == 4'd0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/hmmm_multicycle_core.sv
// Multicycle HMMM core with valid/ready instruction and data ports, HALT and illegal-opcode trap.
// states: IDLE after reset | FETCH wait on imem | EXEC decode/retire | MEM wait on dmem | HALT sticky stop
module hmmm_multicycle_core
  import hmmm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NREGS      = 16,
  parameter int PC_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ready,
  input  logic [INSTR_W-1:0]    imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  halted,
  output logic                  illegal
);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic                  illegal_q, illegal_d;

  logic [3:0]            op;
  logic [3:0]            rx_idx, ry_idx, rz_idx;
  logic                  use_rz;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic [DATA_WIDTH-1:0] imm_w;
  logic [PC_WIDTH-1:0]   target;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  taken;
  logic                  rf_we;
  logic [DATA_WIDTH-1:0] rf_wdata;

  assign op     = ir_q[OP_MSB:OP_LSB];
  assign rx_idx = reg_idx(ir_q[RX_MSB:RX_LSB], NREGS);
  assign ry_idx = reg_idx(ir_q[RY_MSB:RY_LSB], NREGS);
  assign rz_idx = reg_idx(ir_q[RZ_MSB:RZ_LSB], NREGS);
  assign use_rz = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign pc_inc = pc_q + PC_WIDTH'(1);

  // Port A always serves rY (ALU operand / memory address); port B is rZ for ALU ops, rX otherwise.
  hmmm_regfile_p #(
    .DATA_WIDTH (DATA_WIDTH),
    .NREGS      (NREGS)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .ra_addr_i (ry_idx),
    .ra_data_o (rd_a),
    .rb_addr_i (use_rz ? rz_idx : rx_idx),
    .rb_data_o (rd_b),
    .we_i      (rf_we),
    .waddr_i   (rx_idx),
    .wdata_i   (rf_wdata)
  );

  always_comb begin
    imm_w  = '0;
    target = '0;
    for (int i = 0; i < DATA_WIDTH; i++) imm_w[i]  = (i < 8) ? ir_q[i % 8] : ir_q[IMM_MSB];
    for (int i = 0; i < PC_WIDTH; i++)   target[i] = (i < 8) ? ir_q[i % 8] : 1'b0;
  end

  always_comb begin
    alu_res = imm_w;
    case (op)
      OP_ADD:  alu_res = rd_a + rd_b;
      OP_SUB:  alu_res = rd_a - rd_b;
      OP_AND:  alu_res = rd_a & rd_b;
      OP_OR:   alu_res = rd_a | rd_b;
      default: alu_res = imm_w;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_JEQZN: taken = (rd_b == '0);
      OP_JNEZN: taken = (rd_b != '0);
      OP_JGTZN: taken = !rd_b[DATA_WIDTH-1] && (rd_b != '0);
      OP_JLTZN: taken = rd_b[DATA_WIDTH-1];
      OP_JUMPN: taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    illegal_d  = illegal_q;
    rf_we      = 1'b0;
    rf_wdata   = alu_res;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_HALT: state_d = S_HALT;
          OP_SETN, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            rf_we   = 1'b1;
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_JEQZN, OP_JNEZN, OP_JGTZN, OP_JLTZN, OP_JUMPN: begin
            pc_d    = taken ? target : pc_inc;
            state_d = S_FETCH;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = (op == OP_STORE);
        dmem_addr  = rd_a;
        dmem_wdata = rd_b;
        if (dmem_ready) begin
          rf_we    = (op == OP_LOAD);
          rf_wdata = dmem_rdata;
          pc_d     = pc_inc;
          state_d  = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_hmmm_multicycle_core.sv
// Bench for hmmm_multicycle_core: directed programs plus random forward-branching programs vs an ISA-level model.
module tb_hmmm_multicycle_core;

  localparam int DW = 8;
  localparam int PW = 8;

  logic          clk;
  logic          reset;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ready;
  logic [15:0]   imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;
  logic [PW-1:0] pc;
  logic          halted;
  logic          illegal;

  hmmm_multicycle_core #(.DATA_WIDTH(DW), .NREGS(16), .PC_WIDTH(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic [15:0] imem  [256];
  logic [7:0]  dmem  [256];
  logic [7:0]  mdmem [256];
  int  iwait;
  int  dwait;
  bit  inj_iready;

  int act_fetch[$];
  int act_wr[$];
  int d_tx;

  int exp_fetch[$];
  int exp_wr[$];
  int exp_pc;
  int exp_cyc;
  int exp_dtx;
  bit exp_ill;

  int t3_seq [6] = '{0, 1, 16, 17, 18, 48};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Memory responder: drives ready/rdata at negedge, waits iwait/dwait cycles per request.
  task automatic responder();
    int icnt;
    int dcnt;
    logic [PW-1:0] ihold;
    logic [2*DW:0] dhold;
    icnt = 0;
    dcnt = 0;
    ihold = '0;
    dhold = '0;
    forever begin
      @(negedge clk);
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      chk("req_exclusive", {63'b0, imem_req & dmem_req}, 64'd0);
      if (inj_iready) begin
        imem_ready = 1'b1;
        imem_rdata = 16'h0000;
      end else if (imem_req === 1'b1) begin
        if (icnt == 0) ihold = imem_addr;
        else chk("imem_addr_stable", imem_addr, ihold);
        if (icnt >= iwait) begin
          imem_ready = 1'b1;
          imem_rdata = imem[imem_addr];
          act_fetch.push_back(int'(imem_addr));
          icnt = 0;
        end else begin
          icnt++;
        end
      end else begin
        icnt = 0;
      end
      if (dmem_req === 1'b1) begin
        if (dcnt == 0) dhold = {dmem_we, dmem_addr, dmem_wdata};
        else chk("dmem_ctl_stable", {dmem_we, dmem_addr, dmem_wdata}, dhold);
        if (dcnt >= dwait) begin
          dmem_ready = 1'b1;
          d_tx++;
          if (dmem_we) begin
            dmem[dmem_addr] = dmem_wdata;
            act_wr.push_back(int'(dmem_addr) * 256 + int'(dmem_wdata));
          end else begin
            dmem_rdata = dmem[dmem_addr];
          end
          dcnt = 0;
        end else begin
          dmem_rdata = 8'($urandom);
          dcnt++;
        end
      end else begin
        dcnt = 0;
      end
    end
  endtask

  // Instruction-level interpreter: architectural effects and cycle cost per instruction.
  function automatic void model_run();
    int r[16];
    int p;
    int n;
    int op, x, y, z, imm;
    bit tk;
    logic [15:0] ins;
    exp_fetch.delete();
    exp_wr.delete();
    exp_cyc = 1;
    exp_dtx = 0;
    exp_ill = 0;
    exp_pc  = 0;
    foreach (r[i]) r[i] = 0;
    p = 0;
    n = 0;
    while (n < 1000) begin
      n++;
      ins = imem[p];
      exp_fetch.push_back(p);
      exp_cyc += iwait + 2;
      op  = int'(ins[15:12]);
      x   = int'(ins[11:8]);
      y   = int'(ins[7:4]);
      z   = int'(ins[3:0]);
      imm = int'(ins[7:0]);
      tk  = 0;
      case (op)
        0: begin exp_pc = p; return; end
        1: r[x] = imm;
        2: begin r[x] = int'(mdmem[r[y]]); exp_cyc += dwait + 1; exp_dtx++; end
        3: begin
          mdmem[r[y]] = 8'(r[x]);
          exp_wr.push_back(r[y] * 256 + r[x]);
          exp_cyc += dwait + 1;
          exp_dtx++;
        end
        4: r[x] = (r[y] + r[z]) % 256;
        5: r[x] = (r[y] - r[z] + 256) % 256;
        6: r[x] = r[y] & r[z];
        7: r[x] = r[y] | r[z];
        8: tk = (r[x] == 0);
        9: tk = (r[x] != 0);
        10: tk = (r[x] > 0) && (r[x] < 128);
        11: tk = (r[x] >= 128);
        12: tk = 1;
        default: begin exp_pc = p; exp_ill = 1; return; end
      endcase
      r[0] = 0;
      p = tk ? imm : (p + 1) % 256;
    end
  endfunction

  task automatic clear_imem();
    foreach (imem[i]) imem[i] = 16'hF000;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {27'b0, imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, pc, halted, illegal}, 64'd0);
    act_fetch.delete();
    act_wr.delete();
    d_tx = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int start, output int cyc);
    cyc = start;
    while (cyc < 3000 && halted !== 1'b1) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic compare(input string tag, input int cyc);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_illegal"}, illegal, exp_ill);
    chk({tag, "_fetch_count"}, act_fetch.size(), exp_fetch.size());
    for (int i = 0; i < exp_fetch.size() && i < act_fetch.size(); i++)
      chk({tag, "_fetch_addr"}, act_fetch[i], exp_fetch[i]);
    chk({tag, "_write_count"}, act_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
      chk({tag, "_write"}, act_wr[i], exp_wr[i]);
    chk({tag, "_dmem_tx"}, d_tx, exp_dtx);
  endtask

  task automatic run_prog(input string tag);
    int cyc;
    mdmem = dmem;
    model_run();
    reset_dut();
    wait_halt(0, cyc);
    compare(tag, cyc);
  endtask

  initial begin
    int cyc;
    int n;
    int n_bad;
    int body;
    int len;
    logic [3:0] op4, x4, y4, z4;
    logic [7:0] imm8;
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    inj_iready = 1'b0;
    iwait      = 0;
    dwait      = 0;
    d_tx       = 0;
    foreach (dmem[i]) dmem[i] = 8'($urandom);
    fork
      responder();
    join_none

    // Directed 1: add with negative immediate, single store.
    clear_imem();
    imem[0] = 16'h1105; imem[1] = 16'h12FD; imem[2] = 16'h4312; imem[3] = 16'h3300; imem[4] = 16'h0000;
    run_prog("t1");
    chk("t1_write_const", (act_wr.size() == 1) ? act_wr[0] : -1, 32'h0002);
    chk("t1_pc_const", pc, 8'h04);
    chk("t1_cycles_const", exp_cyc, 12);

    // Directed 2: subtract wrap and discarded r0 write.
    clear_imem();
    imem[0] = 16'h1180; imem[1] = 16'h5201; imem[2] = 16'h4011; imem[3] = 16'h3200; imem[4] = 16'h0000;
    run_prog("t2");
    chk("t2_write_const", (act_wr.size() == 1) ? act_wr[0] : -1, 32'h0080);
    chk("t2_pc_const", pc, 8'h04);

    // Directed 3: branch taken / not taken / signed negative.
    clear_imem();
    imem[0] = 16'h1100; imem[1] = 16'h8110;
    imem[16] = 16'h1180; imem[17] = 16'hA120; imem[18] = 16'hB130; imem[48] = 16'h0000;
    run_prog("t3");
    chk("t3_fetch_count_const", act_fetch.size(), 6);
    for (int i = 0; i < 6 && i < act_fetch.size(); i++) chk("t3_fetch_seq_const", act_fetch[i], t3_seq[i]);
    chk("t3_pc_const", pc, 8'h30);

    // Directed 4: wait states on both ports.
    clear_imem();
    imem[0] = 16'h1120; imem[1] = 16'h2410; imem[2] = 16'h3400; imem[3] = 16'h0000;
    dmem[32] = 8'h5A;
    iwait = 3; dwait = 2;
    run_prog("t4");
    chk("t4_write_const", (act_wr.size() == 1) ? act_wr[0] : -1, 32'h005A);
    chk("t4_cycles_const", exp_cyc, 27);
    chk("t4_fetch_count_const", act_fetch.size(), 4);
    chk("t4_dmem_tx_const", d_tx, 2);

    // Directed 5: reset during a store, ready pulse during IDLE.
    clear_imem();
    imem[0] = 16'h1133; imem[1] = 16'h3100; imem[2] = 16'h0000;
    iwait = 0; dwait = 5;
    mdmem = dmem;
    model_run();
    reset_dut();
    n = 0;
    while (dmem_req !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_mem_reached", dmem_req, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_dmem_req_async_drop", dmem_req, 0);
    chk("t5_idle_outputs", {imem_req, dmem_req, pc, halted, illegal}, 12'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_abandoned_write", act_wr.size(), 0);
    act_fetch.delete();
    act_wr.delete();
    d_tx = 0;
    reset = 1'b0;
    inj_iready = 1'b1;
    @(posedge clk);
    #1;
    inj_iready = 1'b0;
    chk("t5_fetch_req_after_idle", imem_req, 1);
    chk("t5_fetch_addr_after_idle", imem_addr, 8'h00);
    wait_halt(1, cyc);
    compare("t5", cyc);
    chk("t5_write_const", (act_wr.size() == 1) ? act_wr[0] : -1, 32'h0033);

    // Directed 6: illegal opcode then plain HALT.
    clear_imem();
    imem[0] = 16'h1101; imem[1] = 16'hD000;
    iwait = 0; dwait = 0;
    run_prog("t6a");
    chk("t6a_illegal_const", illegal, 1);
    chk("t6a_pc_const", pc, 8'h01);
    n_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || pc !== 8'h01 || halted !== 1'b1) n_bad++;
    end
    chk("t6a_sticky_quiet", n_bad, 0);
    chk("t6a_no_more_fetches", act_fetch.size(), 2);
    clear_imem();
    imem[0] = 16'h0000;
    run_prog("t6b");
    chk("t6b_illegal_const", illegal, 0);
    chk("t6b_pc_const", pc, 8'h00);

    // Random forward-branching programs; epilogue stores every register to address 0.
    for (int t = 0; t < 12; t++) begin
      clear_imem();
      foreach (dmem[i]) dmem[i] = 8'($urandom);
      body = $urandom_range(6, 20);
      len  = body + 16;
      for (int k = 0; k < body; k++) begin
        op4  = 4'($urandom_range(1, 12));
        x4   = 4'($urandom);
        y4   = 4'($urandom);
        z4   = 4'($urandom);
        imm8 = 8'($urandom);
        if (op4 >= 4'h8) imm8 = 8'($urandom_range(k + 1, len - 1));
        if (op4 == 4'h1 || op4 >= 4'h8) imem[k] = {op4, x4, imm8};
        else imem[k] = {op4, x4, y4, z4};
      end
      for (int r = 1; r < 16; r++) imem[body + r - 1] = {4'h3, 4'(r), 8'h00};
      n = $urandom_range(0, 3);
      imem[len - 1] = (n == 0) ? 16'h0000 : {4'(12 + n), 12'h000};
      iwait = $urandom_range(0, 2);
      dwait = $urandom_range(0, 2);
      run_prog("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
